// File: rtl/ifu_if.sv
// IFU bus bundle: fetch request/response path,
// decoder handoff and execute-stage redirect.
interface ifu_if #(
  parameter int unsigned DATA_LEN = 32
);
  logic                jump_flag;
  logic [DATA_LEN-1:0] jump_pc;

  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [DATA_LEN-1:0] mem_req_addr;

  logic                mem_rsp_valid;
  logic [31:0]         mem_rsp_data;
  logic                mem_rsp_err;

  logic [31:0]         inst_in;
  logic [DATA_LEN-1:0] PC;
  logic                inst_valid;
  logic                inst_ready;
  logic                fetch_fault;

  // Fetch unit side.
  modport master (
    input  jump_flag,
    input  jump_pc,
    output mem_req_valid,
    input  mem_req_ready,
    output mem_req_addr,
    input  mem_rsp_valid,
    input  mem_rsp_data,
    input  mem_rsp_err,
    output inst_in,
    output PC,
    output inst_valid,
    input  inst_ready,
    output fetch_fault
  );

  // Memory / decoder / execute side.
  modport slave (
    output jump_flag,
    output jump_pc,
    input  mem_req_valid,
    output mem_req_ready,
    input  mem_req_addr,
    output mem_rsp_valid,
    output mem_rsp_data,
    output mem_rsp_err,
    input  inst_in,
    input  PC,
    input  inst_valid,
    output inst_ready,
    input  fetch_fault
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding request,
// registered outputs, redirect with stale-response kill.
module ifu #(
  parameter int unsigned         DATA_LEN = 32,
  parameter logic [DATA_LEN-1:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0]         NOP_INST = 32'h0000_0013
) (
  input logic   clk,
  input logic   rst,
  ifu_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_e;

  localparam logic [DATA_LEN-1:0] STEP = DATA_LEN'(4);

  state_e              state_q, state_d;
  logic [DATA_LEN-1:0] fetch_pc_q, fetch_pc_d;
  logic                kill_q, kill_d;
  logic                req_valid_q, req_valid_d;
  logic [DATA_LEN-1:0] req_addr_q, req_addr_d;
  logic [31:0]         inst_q, inst_d;
  logic [DATA_LEN-1:0] pc_q, pc_d;
  logic                valid_q, valid_d;
  logic                fault_q, fault_d;

  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.inst_in       = inst_q;
  assign bus.PC            = pc_q;
  assign bus.inst_valid    = valid_q;
  assign bus.fetch_fault   = fault_q;

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    kill_d      = kill_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    inst_d      = inst_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    fault_d     = fault_q;

    unique case (state_q)
      IDLE: begin
        if (bus.jump_flag) begin
          fetch_pc_d = bus.jump_pc;
        end
        state_d     = REQ;
        req_valid_d = 1'b1;
        req_addr_d  = fetch_pc_d;
      end

      REQ: begin
        // A redirect here cannot retract the
        // request already on the bus; its
        // response is dropped via kill.
        if (bus.jump_flag) begin
          fetch_pc_d = bus.jump_pc;
          kill_d     = 1'b1;
        end
        if (bus.mem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = WAIT;
        end
      end

      WAIT: begin
        if (bus.mem_rsp_valid) begin
          if (kill_q || bus.jump_flag) begin
            if (bus.jump_flag) begin
              fetch_pc_d = bus.jump_pc;
            end
            kill_d      = 1'b0;
            state_d     = REQ;
            req_valid_d = 1'b1;
            req_addr_d  = fetch_pc_d;
          end else begin
            state_d = HOLD;
            valid_d = 1'b1;
            pc_d    = fetch_pc_q;
            fault_d = bus.mem_rsp_err;
            inst_d  = bus.mem_rsp_err ? NOP_INST
                                      : bus.mem_rsp_data;
          end
        end else if (bus.jump_flag) begin
          kill_d     = 1'b1;
          fetch_pc_d = bus.jump_pc;
        end
      end

      HOLD: begin
        // Redirect wins over a same-cycle accept.
        if (bus.jump_flag || bus.inst_ready) begin
          fetch_pc_d  = bus.jump_flag ? bus.jump_pc
                                      : fetch_pc_q + STEP;
          valid_d     = 1'b0;
          inst_d      = NOP_INST;
          fault_d     = 1'b0;
          state_d     = REQ;
          req_valid_d = 1'b1;
          req_addr_d  = fetch_pc_d;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      kill_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= RESET_PC;
      inst_q      <= NOP_INST;
      pc_q        <= RESET_PC;
      valid_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      kill_q      <= kill_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      fault_q     <= fault_d;
    end
  end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter DATA_LEN, default 32: PC and address width.
REQ-002 Parameter RESET_PC, default 32'h8000_0000: first fetch address after reset.
REQ-003 Parameter NOP_INST, default 32'h0000_0013: instruction driven when idle or faulted.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 jump_flag  input  1  redirect request from the execute stage.
REQ-007 jump_pc  input  DATA_LEN  redirect target, valid while jump_flag=1.
REQ-008 mem_req_valid  output  1  fetch request valid.
REQ-009 mem_req_ready  input  1  memory accepts the request.
REQ-010 mem_req_addr  output  DATA_LEN  fetch address.
REQ-011 mem_rsp_valid  input  1  fetch response valid; no back-pressure exists on the response path.
REQ-012 mem_rsp_data  input  32  fetched instruction word.
REQ-013 mem_rsp_err  input  1  access fault for this response.
REQ-014 inst_in  output  32  instruction to the decoder.
REQ-015 PC  output  DATA_LEN  address of inst_in.
REQ-016 inst_valid  output  1  inst_in and PC are valid.
REQ-017 inst_ready  input  1  decoder accepts the instruction.
REQ-018 fetch_fault  output  1  the presented instruction is a faulted fetch.

Function
REQ-019 The block SHALL use the states IDLE, REQ, WAIT and HOLD, and SHALL drive every output from registers.
REQ-020 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-021 In REQ the block SHALL assert mem_req_valid with mem_req_addr equal to fetch_pc, holding both stable until mem_req_valid&mem_req_ready, then go to WAIT.
REQ-022 In WAIT, mem_rsp_valid SHALL be accepted no earlier than the cycle after request acceptance; on acceptance the block SHALL go to HOLD.
REQ-023 On entry to HOLD the block SHALL capture inst_in=mem_rsp_data, PC=fetch_pc, fetch_fault=mem_rsp_err and inst_valid=1.
REQ-024 When mem_rsp_err=1, inst_in SHALL be NOP_INST.
REQ-025 In HOLD, inst_in, PC and fetch_fault SHALL remain stable until a transfer occurs; a transfer is inst_valid&inst_ready&~jump_flag.
REQ-026 On a transfer the block SHALL clear inst_valid, set fetch_pc=fetch_pc+4 modulo 2^DATA_LEN (32'hFFFF_FFFC wraps to 0) and go to REQ.
REQ-027 Minimum issue interval: REQ->WAIT->HOLD->REQ, 3 cycles per instruction with zero-wait memory and inst_ready=1.
REQ-028 jump_flag in IDLE or REQ without request acceptance SHALL load fetch_pc=jump_pc; in REQ the pending request SHALL complete on the old address and its response SHALL be discarded.
REQ-029 jump_flag in REQ with acceptance in the same cycle, or in WAIT, SHALL set a kill flag and load fetch_pc=jump_pc.
REQ-030 A response arriving while kill=1 SHALL be discarded, SHALL clear kill and SHALL return the block to REQ without asserting inst_valid.
REQ-031 jump_flag in HOLD SHALL discard the held instruction: inst_valid=0 next cycle, fetch_pc=jump_pc, state REQ; this applies even when inst_ready=1 in the same cycle.
REQ-032 jump_flag in the same cycle as mem_rsp_valid in WAIT SHALL discard that response and refetch from jump_pc.
REQ-033 For repeated jump_flag assertions, the latest jump_pc SHALL win.
REQ-034 mem_rsp_valid outside WAIT SHALL be ignored.
REQ-035 The block SHALL keep at most one request outstanding.

Reset
REQ-036 While rst=1, state SHALL be IDLE and fetch_pc SHALL be RESET_PC.
REQ-037 While rst=1: mem_req_valid=0, mem_req_addr=RESET_PC, inst_valid=0, inst_in=NOP_INST, PC=RESET_PC, fetch_fault=0, kill=0.
REQ-038 Reset asserted mid-transaction SHALL abandon the transaction; a late response after release SHALL be ignored per REQ-034.

Verification
REQ-039 Reset release, zero-wait memory, inst_ready=1 -> mem_req_valid rises 1 cycle after release at addr 8000_0000; consecutive fetches at 8000_0000, 8000_0004, 8000_0008 arrive 3 cycles apart.
REQ-040 inst_ready=0 for 5 cycles in HOLD with data 0x00500093 -> inst_in, PC and inst_valid stable all 5 cycles; no new mem_req_valid issued.
REQ-041 jump_flag=1 with jump_pc=8000_0100 in WAIT, response 0xDEADBEEF arrives 2 cycles later -> 0xDEADBEEF never presented; next request addr=8000_0100.
REQ-042 jump_flag and inst_ready both 1 in HOLD at PC=8000_0010 -> no transfer; next request addr=jump_pc, not 8000_0014.
REQ-043 mem_rsp_err=1 for fetch at 8000_0020 -> inst_valid=1, fetch_fault=1, inst_in=0000_0013, PC=8000_0020.
REQ-044 RESET_PC=FFFF_FFFC, one transfer -> next mem_req_addr=0000_0000.
